// File: rtl/delay_line_mc.sv
// Purpose: multi-channel, runtime-programmable, stallable delay line that tags every
//          sample with a valid bit and only advances on enabled cycles. Used to skew
//          boundary-cell outputs against internal-cell operands in the QRD-RLS array.
// Latency: a sample taken on enabled edge k appears on dout after enabled edge k+cur_delay-1.
// Backpressure: none; en=0 freezes all state, one sample accepted per enabled cycle.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en              advance enable
//   cfg_load        one-cycle pulse: latch clamped cfg_delay and flush the line
//   cfg_delay       requested delay in enabled cycles (0 -> 1, >MAX_DELAY -> MAX_DELAY)
//   din, din_valid  input lanes (lane c at [c*DATA_LENGTH +: DATA_LENGTH]) and valid tag
//   dout, dout_valid delayed lanes and valid tag (valid only once the line has filled)
//   cur_delay       delay in force
//   filled          line holds at least cur_delay post-flush samples
//
// Build option: define DLY_CLEAR_DATA_EN to force dout to zero whenever dout_valid=0.
// Without it dout shows raw buffer contents and only dout_valid qualifies them.

module delay_line_mc #(
  parameter  int DATA_LENGTH = 8,
  parameter  int CHANNELS    = 3,
  parameter  int MAX_DELAY   = 32,
  parameter  int RESET_DELAY = 21,
  localparam int DW          = $clog2(MAX_DELAY + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic                            cfg_load,
  input  logic [DW-1:0]                   cfg_delay,
  input  logic [CHANNELS*DATA_LENGTH-1:0] din,
  input  logic                            din_valid,
  output logic [CHANNELS*DATA_LENGTH-1:0] dout,
  output logic                            dout_valid,
  output logic [DW-1:0]                   cur_delay,
  output logic                            filled
);

  localparam int PW = $clog2(MAX_DELAY);
  localparam int WW = CHANNELS * DATA_LENGTH;

  localparam logic [DW-1:0] MAX_D  = DW'(MAX_DELAY);
  localparam logic [DW-1:0] RST_D  = DW'(RESET_DELAY);
  localparam logic [PW-1:0] LAST_P = PW'(MAX_DELAY - 1);
  // Wraps to zero when MAX_DELAY is a power of two; the subtraction below is then
  // naturally modulo 2**PW, which is exactly modulo MAX_DELAY.
  localparam logic [PW-1:0] MAX_P  = PW'(MAX_DELAY);

  // Circular buffer: {valid, data} per entry. Contents are deliberately not reset;
  // the fill counter keeps stale entries from ever being reported valid.
  logic [WW:0]    mem [MAX_DELAY];

  logic [PW-1:0]  wr_ptr;
  logic [DW-1:0]  fill;
  logic [DW-1:0]  cur_delay_q;
  logic [WW-1:0]  dout_q;
  logic           dout_valid_q;

  logic [DW-1:0]  dly_eff;
  logic [DW-1:0]  fill_base;
  logic [DW-1:0]  fill_nxt;
  logic [PW-1:0]  back_off;
  logic [PW-1:0]  rd_addr;
  logic [WW:0]    rd_entry;
  logic           rd_vld;
  logic [WW-1:0]  rd_dat;

  function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
    if (d == '0) begin
      return DW'(1);
    end else if (d > MAX_D) begin
      return MAX_D;
    end else begin
      return d;
    end
  endfunction

  always_comb begin
    // A load on this edge takes effect immediately: the fill restarts from zero and the
    // read uses the new delay, so the sample written on the load edge is the first
    // post-flush sample.
    dly_eff   = cfg_load ? clamp_delay(cfg_delay) : cur_delay_q;
    fill_base = cfg_load ? '0 : fill;
    fill_nxt  = (fill_base == dly_eff) ? fill_base : fill_base + DW'(1);

    // Read the entry written (delay-1) edges before the current write slot.
    back_off = PW'(dly_eff - DW'(1));
    if (wr_ptr >= back_off) begin
      rd_addr = wr_ptr - back_off;
    end else begin
      rd_addr = wr_ptr - back_off + MAX_P;
    end

    // Delay 1 reads the slot being written this edge, so bypass the incoming sample.
    if (rd_addr == wr_ptr) begin
      rd_entry = {din_valid, din};
    end else begin
      rd_entry = mem[rd_addr];
    end

    // The load edge always reports invalid, even for delay 1.
    rd_vld = rd_entry[WW] && (fill_nxt == dly_eff) && !cfg_load;

`ifdef DLY_CLEAR_DATA_EN
    rd_dat = rd_vld ? rd_entry[WW-1:0] : '0;
`else
    rd_dat = rd_entry[WW-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      fill         <= '0;
      cur_delay_q  <= RST_D;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      if (cfg_load) begin
        cur_delay_q <= dly_eff;
      end
      if (en) begin
        wr_ptr       <= (wr_ptr == LAST_P) ? '0 : wr_ptr + PW'(1);
        fill         <= fill_nxt;
        dout_q       <= rd_dat;
        dout_valid_q <= rd_vld;
      end else if (cfg_load) begin
        // Flush while stalled: no write, no pointer move, but the line empties.
        fill         <= '0;
        dout_valid_q <= 1'b0;
`ifdef DLY_CLEAR_DATA_EN
        dout_q       <= '0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && en) begin
      mem[wr_ptr] <= {din_valid, din};
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign cur_delay  = cur_delay_q;
  assign filled     = (fill == cur_delay_q);

endmodule
